// File: rtl/synch_debounce_multi_pkg.sv
// Shared constants and helpers for the multi-channel input synchroniser.
package synch_pkg;

    localparam int DEF_STAGES   = 3;
    localparam int DEF_DEBOUNCE = 4;

    // Bits needed to hold values 0..n-1 of an n-state counter; never less than one.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/synch_debounce_multi_if.sv
// Channel bundle between the board-facing inputs and the CLK-domain consumers.
interface synch_debounce_multi_if #(parameter int WIDTH = 4);

    logic [WIDTH-1:0] ASYNC_IN;
    logic [WIDTH-1:0] SYNC_OUT;
    logic [WIDTH-1:0] STABLE_OUT;
    logic [WIDTH-1:0] RISE;
    logic [WIDTH-1:0] FALL;

    // No handshake: ASYNC_IN is free-running, outputs are level/pulse valid every cycle.
    modport master (output ASYNC_IN, input SYNC_OUT, STABLE_OUT, RISE, FALL);
    modport slave  (input ASYNC_IN, output SYNC_OUT, STABLE_OUT, RISE, FALL);

endinterface

// File: rtl/synch_debounce_multi_debounce_chan.sv
// One channel: flop-chain synchroniser, consecutive-cycle debounce filter and
// registered rise/fall pulses that coincide with the stable value changing.
module debounce_chan
    import synch_pkg::*;
#(
    parameter int   STAGES       = DEF_STAGES,
    parameter int   DEBOUNCE_CYC = DEF_DEBOUNCE,
    parameter logic RST_VAL      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic stable_out,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(DEBOUNCE_CYC + 1);

    logic [STAGES-1:0] chain;
    logic [CW-1:0]     cnt;

    assign sync_out = chain[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain      <= {STAGES{RST_VAL}};
            cnt        <= '0;
            stable_out <= RST_VAL;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            rise  <= 1'b0;
            fall  <= 1'b0;
            // Any return to agreement throws away the partial count.
            if (sync_out == stable_out) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                stable_out <= sync_out;
                cnt        <= '0;
                rise       <= sync_out;
                fall       <= ~sync_out;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/synch_debounce_multi.sv
// WIDTH independent synchroniser/debounce/edge channels behind one interface port.
module synch_debounce_multi
    import synch_pkg::*;
#(
    parameter int               WIDTH        = 4,
    parameter int               STAGES       = DEF_STAGES,
    parameter logic [WIDTH-1:0] RST_VAL      = {WIDTH{1'b1}},
    parameter int               DEBOUNCE_CYC = DEF_DEBOUNCE
) (
    input  logic                  CLK,
    input  logic                  RST,
    synch_debounce_multi_if.slave bus
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_chan #(
            .STAGES      (STAGES),
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .RST_VAL     (RST_VAL[i])
        ) u_chan (
            .clk       (CLK),
            .rst       (RST),
            .async_in  (bus.ASYNC_IN[i]),
            .sync_out  (bus.SYNC_OUT[i]),
            .stable_out(bus.STABLE_OUT[i]),
            .rise      (bus.RISE[i]),
            .fall      (bus.FALL[i])
        );
    end

endmodule

// File: tb/tb_synch_debounce_multi.sv
// Bench for synch_debounce_multi: default build plus a WIDTH=1/STAGES=2/DEBOUNCE_CYC=1 corner build.
module tb_synch_debounce_multi;

    logic       CLK;
    logic       RST;
    logic [3:0] a_in;
    logic       a_in2;
    int         total;
    int         bad;
    int         rise_cnt[4];
    int         fall_cnt[4];

    synch_debounce_multi_if #(.WIDTH(4)) bus1 ();
    synch_debounce_multi_if #(.WIDTH(1)) bus2 ();

    assign bus1.ASYNC_IN = a_in;
    assign bus2.ASYNC_IN = a_in2;

    synch_debounce_multi #(.WIDTH(4), .STAGES(3), .RST_VAL(4'hF), .DEBOUNCE_CYC(4)) dut1 (
        .CLK(CLK), .RST(RST), .bus(bus1.slave)
    );
    synch_debounce_multi #(.WIDTH(1), .STAGES(2), .RST_VAL(1'b0), .DEBOUNCE_CYC(1)) dut2 (
        .CLK(CLK), .RST(RST), .bus(bus2.slave)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    // Histories since reset release: newest entry at index 0.
    typedef struct packed {
        logic [7:0][3:0] in_h;
        logic [7:0][3:0] pre_h;
        logic [3:0]      sync;
        logic [3:0]      stable;
        logic [3:0]      rise;
        logic [3:0]      fall;
        logic [3:0]      n;
    } mstate_t;

    function automatic mstate_t model_reset(input logic [3:0] rv);
        mstate_t r;
        r        = '0;
        r.sync   = rv;
        r.stable = rv;
        return r;
    endfunction

    // Sync = input sampled STAGES edges ago; stable flips when the last
    // DEBOUNCE_CYC pre-edge sync values all disagreed with it.
    function automatic mstate_t model_step(input mstate_t s, input logic [3:0] a,
                                           input int stages, input int dcyc,
                                           input logic [3:0] rv);
        mstate_t r;
        logic    all_diff;
        r       = s;
        r.in_h  = {s.in_h[6:0], a};
        r.pre_h = {s.pre_h[6:0], s.sync};
        if (s.n != 4'hF) r.n = s.n + 4'd1;
        r.sync = (int'(r.n) >= stages) ? r.in_h[stages-1] : rv;
        for (int ch = 0; ch < 4; ch++) begin
            all_diff = (int'(r.n) >= dcyc);
            for (int j = 0; j < dcyc; j++)
                if (r.pre_h[j][ch] == s.stable[ch]) all_diff = 1'b0;
            if (all_diff) r.stable[ch] = ~s.stable[ch];
        end
        r.rise = r.stable & ~s.stable;
        r.fall = ~r.stable & s.stable;
        return r;
    endfunction

    mstate_t ms1, ms2;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ms1 <= model_reset(4'hF);
            ms2 <= model_reset(4'h0);
        end else begin
            ms1 <= model_step(ms1, a_in, 3, 4, 4'hF);
            ms2 <= model_step(ms2, {3'b000, a_in2}, 2, 1, 4'h0);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        check("sync_out",   bus1.SYNC_OUT,   ms1.sync);
        check("stable_out", bus1.STABLE_OUT, ms1.stable);
        check("rise",       bus1.RISE,       ms1.rise);
        check("fall",       bus1.FALL,       ms1.fall);
        check("c_sync",     {3'b000, bus2.SYNC_OUT},   {3'b000, ms2.sync[0]});
        check("c_stable",   {3'b000, bus2.STABLE_OUT}, {3'b000, ms2.stable[0]});
        check("c_rise",     {3'b000, bus2.RISE},       {3'b000, ms2.rise[0]});
        check("c_fall",     {3'b000, bus2.FALL},       {3'b000, ms2.fall[0]});
        for (int ch = 0; ch < 4; ch++) begin
            if (bus1.RISE[ch]) rise_cnt[ch] = rise_cnt[ch] + 1;
            if (bus1.FALL[ch]) fall_cnt[ch] = fall_cnt[ch] + 1;
        end
    end

    // ---------------- driver ----------------
    task automatic step(input int k);
        repeat (k) @(negedge CLK);
    endtask

    int f_snap, r_snap;

    initial begin
        total = 0;
        bad   = 0;
        for (int ch = 0; ch < 4; ch++) begin
            rise_cnt[ch] = 0;
            fall_cnt[ch] = 0;
        end
        a_in  = 4'h0;
        a_in2 = 1'b0;
        RST   = 1'b1;
        #1;
        check("pwrup_sync",   bus1.SYNC_OUT,   4'hF);
        check("pwrup_stable", bus1.STABLE_OUT, 4'hF);
        check("pwrup_pulse",  bus1.RISE | bus1.FALL, 4'h0);

        // Release with inputs matching reset value: no pulse.
        a_in = 4'hF;
        step(3);
        RST = 1'b0;
        r_snap = rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3];
        f_snap = fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3];
        step(10);
        check("rel_rise_cnt", 4'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3] - r_snap), 4'h0);
        check("rel_fall_cnt", 4'(fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3] - f_snap), 4'h0);

        // Clean fall on ch0: sync after 3 edges, stable + FALL after 7.
        a_in = 4'hE;
        step(2);
        check("t2_sync_2e", bus1.SYNC_OUT, 4'hF);
        step(1);
        check("t2_sync_3e", bus1.SYNC_OUT, 4'hE);
        step(3);
        check("t2_stable_6e", bus1.STABLE_OUT, 4'hF);
        step(1);
        check("t2_stable_7e", bus1.STABLE_OUT, 4'hE);
        check("t2_fall_7e",   bus1.FALL,       4'h1);
        check("t2_rise_7e",   bus1.RISE,       4'h0);
        step(1);
        check("t2_fall_8e", bus1.FALL, 4'h0);

        // Mid-run reset between edges takes effect at once.
        #2 RST = 1'b1;
        #1;
        check("mid_rst_sync",   bus1.SYNC_OUT,   4'hF);
        check("mid_rst_stable", bus1.STABLE_OUT, 4'hF);
        check("mid_rst_pulse",  bus1.RISE | bus1.FALL, 4'h0);
        a_in = 4'hF;
        step(2);
        RST = 1'b0;
        step(10);

        // Glitch of 3 cycles on ch1 is suppressed; 4 cycles passes.
        f_snap = fall_cnt[1];
        a_in = 4'hD;
        step(3);
        a_in = 4'hF;
        step(12);
        check("t3_glitch_stable", bus1.STABLE_OUT, 4'hF);
        check("t3_glitch_fall",   4'(fall_cnt[1] - f_snap), 4'h0);
        a_in = 4'hD;
        step(4);
        a_in = 4'hF;
        step(3);
        check("t3_fall_4cyc", bus1.FALL, 4'h2);
        step(12);
        check("t3_recover", bus1.STABLE_OUT, 4'hF);

        // Simultaneous opposite edges on ch2/ch3.
        a_in = 4'h7;
        step(10);
        check("t4_preset", bus1.STABLE_OUT, 4'h7);
        a_in = 4'hB;
        step(7);
        check("t4_fall", bus1.FALL, 4'h4);
        check("t4_rise", bus1.RISE, 4'h8);
        step(1);
        check("t4_gone", bus1.FALL | bus1.RISE, 4'h0);
        a_in = 4'hF;
        step(10);

        // Bounce on ch0 then settle low: exactly one FALL, 7 edges after settle.
        f_snap = fall_cnt[0];
        for (int i = 0; i < 10; i++) begin
            a_in[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        a_in[0] = 1'b0;
        step(6);
        check("t5_no_early", bus1.STABLE_OUT, 4'hF);
        step(1);
        check("t5_fall", bus1.FALL, 4'h1);
        step(10);
        check("t5_one_pulse", 4'(fall_cnt[0] - f_snap), 4'h1);
        a_in = 4'hF;
        step(10);

        // Corner build: sync after 2 edges, stable/RISE after 3, 1-cycle glitch passes.
        a_in2 = 1'b1;
        step(2);
        check("t6_sync_2e",   {3'b000, bus2.SYNC_OUT},   4'h1);
        check("t6_stable_2e", {3'b000, bus2.STABLE_OUT}, 4'h0);
        step(1);
        check("t6_stable_3e", {3'b000, bus2.STABLE_OUT}, 4'h1);
        check("t6_rise_3e",   {3'b000, bus2.RISE},       4'h1);
        step(2);
        a_in2 = 1'b0;
        step(1);
        a_in2 = 1'b1;
        step(2);
        check("t6_glitch_fall", {3'b000, bus2.FALL}, 4'h1);
        step(1);
        check("t6_glitch_rise", {3'b000, bus2.RISE}, 4'h1);

        // Randomised traffic with one asynchronous reset in the middle.
        for (int c = 0; c < 600; c++) begin
            step(1);
            for (int ch = 0; ch < 4; ch++)
                if ($urandom_range(0, 3) == 0) a_in[ch] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) a_in2 = 1'($urandom_range(0, 1));
            if (c == 300) begin
                #3 RST = 1'b1;
                step(1);
                RST = 1'b0;
            end
        end
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/synch_debounce_multi.md
Name: synch_debounce_multi

Overview:
- Parametrised multi-channel synchroniser for asynchronous inputs such as buttons, switches and external strobes.
- Each channel passes through an N-stage flop chain, then a per-channel debounce filter, then a rise/fall edge detector.
- Sits at the chip/board boundary and feeds clean, single-cycle event pulses to control FSMs in the CLK domain.

Parameters:
- WIDTH, 4: number of independent channels (>=1).
- STAGES, 3: synchroniser flops per channel (>=2).
- RST_VAL, {WIDTH{1'b1}}: per-channel reset value, applied to the sync chain and to STABLE_OUT.
- DEBOUNCE_CYC, 4: consecutive cycles SYNC_OUT must differ from STABLE_OUT before STABLE_OUT updates (>=1; 1 = no filtering).

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- ASYNC_IN  in  WIDTH  asynchronous input channels
- SYNC_OUT  out  WIDTH  raw synchronised value (last flop of each chain)
- STABLE_OUT  out  WIDTH  debounced value
- RISE  out  WIDTH  1-cycle pulse when STABLE_OUT[i] goes 0->1
- FALL  out  WIDTH  1-cycle pulse when STABLE_OUT[i] goes 1->0

Behaviour:
- Reset is asynchronous, active-high; clock is CLK. While RST is high:
  - all sync flops and STABLE_OUT = RST_VAL
  - debounce counters = 0
  - RISE = FALL = 0
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge.
- Reset release never produces a RISE/FALL pulse.
- Sync chain: per channel, stage0 <= ASYNC_IN[i], stage k <= stage k-1. SYNC_OUT = last stage. Latency is STAGES edges from the first edge that samples the new level.
- Debounce, per channel, with counter cnt of width $clog2(DEBOUNCE_CYC+1):
  - SYNC_OUT == STABLE_OUT: cnt <= 0.
  - SYNC_OUT != STABLE_OUT and cnt == DEBOUNCE_CYC-1: STABLE_OUT <= SYNC_OUT, cnt <= 0.
  - Otherwise, while they differ: cnt <= cnt+1.
  - Net effect: STABLE_OUT changes DEBOUNCE_CYC edges after SYNC_OUT changes, provided SYNC_OUT holds for that whole window.
  - Any return to equality before the window completes clears cnt. Shorter glitches are fully suppressed; no partial credit is carried over.
  - cnt never exceeds DEBOUNCE_CYC-1, so no wrap-around is possible.
- Edge detect:
  - RISE[i] and FALL[i] are registered and update on the same edge that updates STABLE_OUT[i].
  - They are high for exactly the one cycle during which STABLE_OUT shows its new value.
  - RISE and FALL are never high together on one channel.
- Channels are fully independent. Simultaneous changes on several channels produce their pulses in the same cycle.
- Fixed end-to-end latency from the ASYNC_IN sampling edge to STABLE_OUT/pulse is STAGES + DEBOUNCE_CYC edges.
- No combinational path from ASYNC_IN to any output.

Decomposition:
- Package synch_pkg holds:
  - a clog2-style constant function for counter width
  - default parameter constants: DEF_STAGES=3, DEF_DEBOUNCE=4
- Natural sub-module: debounce_chan, one channel containing sync chain, counter, stable register and edge pulses. It is generated WIDTH times.
- The top level contains only the generate loop and port slicing.

Test Plan (WIDTH=4, STAGES=3, DEBOUNCE_CYC=4, RST_VAL=4'hF unless stated):
1. Power-up and mid-run reset:
   - Stimulus: assert RST between edges while ASYNC_IN=4'h0.
   - Required: SYNC_OUT = STABLE_OUT = 4'hF immediately, RISE = FALL = 0.
   - Required after release with inputs at 4'hF: no pulse.
2. Clean fall on ch0:
   - Stimulus: ASYNC_IN[0] 1->0 and held.
   - Required: SYNC_OUT[0]=0 after 3 edges; STABLE_OUT[0]=0 and FALL[0]=1 for one cycle after 4 more edges (7 total).
   - Required: other channels unchanged.
3. Glitch rejection on ch1:
   - Stimulus: SYNC_OUT[1] low for exactly 3 cycles, then high again.
   - Required: STABLE_OUT[1] stays 1, no FALL.
   - Follow-up: a 4-cycle low afterwards does produce FALL[1].
4. Simultaneous opposite edges:
   - Stimulus: ch2 1->0 and ch3 0->1 (ch3 preset low) on the same edge.
   - Required: FALL[2] and RISE[3] asserted in the same cycle, each one cycle wide.
5. Bounce:
   - Stimulus: ASYNC_IN[0] toggles every 2 cycles for 20 cycles, then settles at 0.
   - Required: exactly one FALL[0] pulse, 7 edges after the final settle.
6. Parameter corner (STAGES=2, DEBOUNCE_CYC=1, WIDTH=1, RST_VAL=0):
   - Stimulus: input 0->1.
   - Required: SYNC_OUT after 2 edges; STABLE_OUT and RISE after 3 edges; a 1-cycle glitch passes through.
